// File: rtl/alu_sched_pkg.sv
// Shared types and packet layout for the round-robin ALU scheduler.
package alu_sched_pkg;

   localparam int DATA_W  = 10;
   localparam int OPA_LSB = 0;
   localparam int OPB_LSB = 4;
   localparam int OP_LSB  = 8;

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_XOR} alu_op_e;
   typedef enum logic {S_IDLE, S_ISSUE} sched_state_e;

   // Round-robin candidate index: base + offset, wrapped into [0, n).
   function automatic int rr_index(input int base, input int offset, input int n);
      int sum;
      sum = base + offset;
      return (sum >= n) ? (sum - n) : sum;
   endfunction

endpackage

// File: rtl/alu_sched_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per command in flight through the ALU.
module sched_tag_fifo
   import alu_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [W-1:0]             push_data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Full is judged on the registered count, so a same-cycle pop never frees room.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU pipeline between NUM_REQ requesters;
// results are steered back to their issuer via an in-order tag FIFO.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int TAG_DEPTH = 8,
   parameter int DATA_W    = alu_sched_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]        req_wvalid,
   output logic [NUM_REQ-1:0]        req_wready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [NUM_REQ-1:0]        rsp_rvalid,
   input  logic [NUM_REQ-1:0]        rsp_rready,
   output logic [DATA_W-1:0]         alu_wdata,
   output logic                      alu_wvalid,
   input  logic                      alu_wready,
   input  logic [DATA_W-1:0]         alu_rdata,
   input  logic                      alu_rvalid,
   output logic                      alu_rready,
   output logic                      busy,
   output logic                      err_orphan
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(TAG_DEPTH) + 1;

   sched_state_e      state_q, state_d;
   logic [DATA_W-1:0] slot_q, slot_d;
   logic [IDW-1:0]    last_grant_q, last_grant_d;
   logic              orphan_q, orphan_d;

   logic              slot_free;
   logic              can_grant;
   logic              grant_found;
   logic [IDW-1:0]    grant_idx;
   logic              accept;

   logic [IDW-1:0]    tag_head;
   logic [CW-1:0]     tag_count;
   logic              tag_full, tag_empty, tag_pop;

   // Slot frees up when empty or when the ALU FIFO takes its packet this cycle.
   assign slot_free = (state_q == S_IDLE) || alu_wready;
   // Gating with reset keeps req_wready low while reset is held.
   assign can_grant = reset && slot_free && !tag_full;
   assign accept    = can_grant && grant_found;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_grant_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!grant_found && req_wvalid[rr_index(int'(last_grant_q), k, NUM_REQ)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(rr_index(int'(last_grant_q), k, NUM_REQ));
         end
      end
   end

   always_comb begin
      req_wready = '0;
      if (accept) req_wready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      last_grant_d = last_grant_q;
      alu_wvalid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            alu_wvalid = 1'b1;
            if (alu_wready) state_d = accept ? S_ISSUE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         slot_d       = req_wdata[grant_idx*DATA_W +: DATA_W];
         last_grant_d = grant_idx;
      end
   end

   assign alu_wdata = slot_q;

   always_comb begin
      rsp_rvalid = '0;
      rsp_rdata  = '0;
      alu_rready = 1'b1;
      if (!tag_empty) begin
         rsp_rvalid[tag_head] = alu_rvalid;
         rsp_rdata            = alu_rdata;
         alu_rready           = rsp_rready[tag_head];
      end
   end

   assign tag_pop  = !tag_empty && alu_rvalid && alu_rready;
   assign orphan_d = orphan_q || (tag_empty && alu_rvalid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         slot_q       <= '0;
         last_grant_q <= IDW'(NUM_REQ - 1);
         orphan_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         last_grant_q <= last_grant_d;
         orphan_q     <= orphan_d;
      end
   end

   assign err_orphan = orphan_q;
   assign busy       = (state_q == S_ISSUE) || (tag_count != '0);

   sched_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .W     (IDW)
   ) u_tag_fifo (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (accept),
      .push_data_i (grant_idx),
      .pop_i       (tag_pop),
      .head_o      (tag_head),
      .count_o     (tag_count),
      .full_o      (tag_full),
      .empty_o     (tag_empty)
   );

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched; the bench itself plays the ALU FIFOs and requesters.
module tb_alu_sched;

   localparam int NR = 4;
   localparam int TD = 8;
   localparam int DW = 10;

   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic [NR*DW-1:0] req_wdata;
   logic [NR-1:0]    req_wvalid, req_wready;
   logic [DW-1:0]    rsp_rdata;
   logic [NR-1:0]    rsp_rvalid, rsp_rready;
   logic [DW-1:0]    alu_wdata, alu_rdata;
   logic             alu_wvalid, alu_wready, alu_rvalid, alu_rready;
   logic             busy, err_orphan;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] fair_pkt [NR] = '{10'h031, 10'h1C2, 10'h2A7, 10'h3E4};

   always #5 clk = ~clk;

   alu_sched #(
      .NUM_REQ   (NR),
      .TAG_DEPTH (TD),
      .DATA_W    (DW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_wdata  (req_wdata),
      .req_wvalid (req_wvalid),
      .req_wready (req_wready),
      .rsp_rdata  (rsp_rdata),
      .rsp_rvalid (rsp_rvalid),
      .rsp_rready (rsp_rready),
      .alu_wdata  (alu_wdata),
      .alu_wvalid (alu_wvalid),
      .alu_wready (alu_wready),
      .alu_rdata  (alu_rdata),
      .alu_rvalid (alu_rvalid),
      .alu_rready (alu_rready),
      .busy       (busy),
      .err_orphan (err_orphan)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic [DW-1:0] d);
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic do_reset;
      reset      = 1'b0;
      req_wvalid = '0;
      rsp_rready = '0;
      alu_rvalid = 1'b0;
      alu_rdata  = '0;
      alu_wready = 1'b1;
      #2;
      reset      = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_wdata  = '0;
      req_wvalid = '0;
      rsp_rready = '0;
      alu_wready = 1'b1;
      alu_rvalid = 1'b0;
      alu_rdata  = '0;
      reset      = 1'b0;
      #3;
      req_wvalid = 4'hF;
      #1;
      check("rst_alu_wvalid", alu_wvalid, 0);
      check("rst_alu_wdata",  alu_wdata,  0);
      check("rst_req_wready", req_wready, 0);
      check("rst_rsp_rvalid", rsp_rvalid, 0);
      check("rst_alu_rready", alu_rready, 1);
      check("rst_busy",       busy,       0);
      check("rst_err_orphan", err_orphan, 0);
      req_wvalid = '0;
      tick();
      reset = 1'b1;
      #1;

      // Single command from requester 0
      put(0, 10'h053);
      req_wvalid = 4'b0001;
      #1;
      check("single_grant", req_wready, 4'b0001);
      tick();
      req_wvalid = '0;
      #1;
      check("single_wvalid", alu_wvalid, 1);
      check("single_wdata",  alu_wdata,  10'h053);
      check("single_busy",   busy,       1);
      tick();
      check("single_handoff", alu_wvalid, 0);
      alu_rvalid = 1'b1;
      alu_rdata  = 10'h008;
      rsp_rready = 4'b0001;
      #1;
      check("single_rsp_rvalid", rsp_rvalid, 4'b0001);
      check("single_rsp_rdata",  rsp_rdata,  10'h008);
      check("single_alu_rready", alu_rready, 1);
      tick();
      alu_rvalid = 1'b0;
      #1;
      check("single_idle_busy", busy,       0);
      check("single_no_orphan", err_orphan, 0);

      // Fairness, then fill the tag FIFO
      tick();
      do_reset();
      for (int i = 0; i < NR; i++) put(i, fair_pkt[i]);
      req_wvalid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("fair_grant", req_wready, 32'd1 << (k % 4));
         tick();
         check("fair_wdata", alu_wdata, fair_pkt[k % 4]);
      end
      #1;
      check("full_block", req_wready, 0);
      check("full_busy",  busy,       1);
      alu_rvalid = 1'b1;
      alu_rdata  = 10'h155;
      rsp_rready = 4'hF;
      #1;
      check("full_rsp_owner",  rsp_rvalid, 4'b0001);
      check("full_rsp_rdata",  rsp_rdata,  10'h155);
      check("full_pop_cycle",  req_wready, 0);
      tick();
      alu_rvalid = 1'b0;
      #1;
      check("full_one_more", req_wready, 4'b0001);
      tick();
      check("full_again", req_wready, 0);
      req_wvalid = '0;
      for (int k = 0; k < 8; k++) begin
         alu_rvalid = 1'b1;
         alu_rdata  = DW'(k);
         #1;
         check("drain_owner", rsp_rvalid, 32'd1 << ((k + 1) % 4));
         tick();
      end
      alu_rvalid = 1'b0;
      #1;
      check("drain_busy", busy, 0);

      // Backpressure while a packet sits in the slot
      tick();
      do_reset();
      alu_wready = 1'b0;
      put(0, 10'h1A5);
      put(1, 10'h2B6);
      req_wvalid = 4'b0001;
      #1;
      check("bp_first_grant", req_wready, 4'b0001);
      tick();
      req_wvalid = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_no_accept", req_wready, 0);
         check("bp_wdata",     alu_wdata,  10'h1A5);
         check("bp_wvalid",    alu_wvalid, 1);
         tick();
      end
      alu_wready = 1'b1;
      #1;
      check("bp_release_grant", req_wready, 4'b0010);
      tick();
      check("bp_next_wdata",  alu_wdata,  10'h2B6);
      check("bp_next_wvalid", alu_wvalid, 1);
      req_wvalid = '0;
      tick();
      check("bp_idle", alu_wvalid, 0);

      // Orphan result, then an owner that is not ready
      do_reset();
      alu_rvalid = 1'b1;
      alu_rdata  = 10'h3FF;
      #1;
      check("orph_rready", alu_rready, 1);
      check("orph_rvalid", rsp_rvalid, 0);
      check("orph_before", err_orphan, 0);
      tick();
      alu_rvalid = 1'b0;
      #1;
      check("orph_set", err_orphan, 1);
      tick();
      tick();
      check("orph_sticky", err_orphan, 1);
      put(2, 10'h0F1);
      req_wvalid = 4'b0100;
      #1;
      check("own_grant", req_wready, 4'b0100);
      tick();
      req_wvalid = '0;
      tick();
      alu_rvalid = 1'b1;
      alu_rdata  = 10'h0AB;
      rsp_rready = 4'b1011;
      #1;
      check("own_rvalid",  rsp_rvalid, 4'b0100);
      check("own_stalled", alu_rready, 0);
      tick();
      check("own_kept_busy",   busy,       1);
      check("own_kept_rvalid", rsp_rvalid, 4'b0100);
      rsp_rready = 4'b0100;
      #1;
      check("own_ready", alu_rready, 1);
      tick();
      alu_rvalid = 1'b0;
      #1;
      check("own_done_busy", busy,       0);
      check("own_orph_kept", err_orphan, 1);

      // Asynchronous reset with three tags outstanding
      tick();
      do_reset();
      put(0, 10'h011);
      put(1, 10'h122);
      put(2, 10'h233);
      req_wvalid = 4'b0111;
      tick();
      tick();
      tick();
      req_wvalid = 4'b0100;
      alu_wready = 1'b0;
      rsp_rready = '0;
      #1;
      check("ar_pre_busy",   busy,       1);
      check("ar_pre_wvalid", alu_wvalid, 1);
      check("ar_pre_rready", alu_rready, 0);
      reset = 1'b0;
      #1;
      check("ar_wvalid", alu_wvalid, 0);
      check("ar_wdata",  alu_wdata,  0);
      check("ar_wready", req_wready, 0);
      check("ar_rvalid", rsp_rvalid, 0);
      check("ar_rready", alu_rready, 1);
      check("ar_busy",   busy,       0);
      check("ar_orphan", err_orphan, 0);
      reset = 1'b1;
      #1;
      check("ar_req2_first", req_wready, 4'b0100);
      req_wvalid = 4'b0101;
      #1;
      check("ar_req0_prio", req_wready, 4'b0001);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one `axi_alu` pipeline (input FIFO → ALU → output FIFO) between `NUM_REQ` requesters.
- Each requester issues 10-bit ALU command packets over a valid/ready channel.
- The block grants one packet at a time, holds it in a single issue slot toward the ALU input FIFO, and records the requester ID in an in-order tag FIFO.
- Results leaving the ALU output FIFO are returned only to the requester that issued them.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `TAG_DEPTH`, 8, maximum outstanding commands, power of two
- `DATA_W`, 10, packet width: [3:0] operand a, [7:4] operand b, [9:8] op

Ports:
- `clk` in 1: single clock; all state on posedge
- `reset` in 1: asynchronous, active-low; asserted when 0
- `req_wdata` in NUM_REQ*DATA_W: command packet, requester i at [i*DATA_W +: DATA_W]
- `req_wvalid` in NUM_REQ: command valid per requester
- `req_wready` out NUM_REQ: one-hot grant/accept
- `rsp_rdata` out DATA_W: result, shared by all requesters
- `rsp_rvalid` out NUM_REQ: one-hot, marks the owner of the current result
- `rsp_rready` in NUM_REQ: result accept per requester
- `alu_wdata` out DATA_W: command toward ALU input FIFO
- `alu_wvalid` out 1
- `alu_wready` in 1
- `alu_rdata` in DATA_W: result from ALU output FIFO
- `alu_rvalid` in 1
- `alu_rready` out 1
- `busy` out 1: issue slot occupied or tag count ≠ 0
- `err_orphan` out 1: sticky; a result arrived with no outstanding tag

## Operation
Issue slot FSM, two states:
- IDLE: slot empty, `alu_wvalid`=0.
- ISSUE: slot holds a packet, `alu_wvalid`=1, `alu_wdata` stable.

Slot is free when in IDLE, or in ISSUE with `alu_wready`=1.

Arbitration (combinational):
- When the slot is free and tag count < TAG_DEPTH, grant the first asserted `req_wvalid` starting at `last_grant+1` (mod NUM_REQ).
- `req_wready` is one-hot on the winner; all zero otherwise.
- Grant never depends on `req_wdata`.

On accept (`req_wvalid[g] && req_wready[g]`):
- Slot loads `req_wdata[g]`.
- `last_grant` ← g.
- Push g into the tag FIFO.
- Next state ISSUE.

FSM transitions:
- ISSUE with `alu_wready`=1 and no accept → IDLE.
- ISSUE with `alu_wready`=1 and an accept → stays ISSUE with the new packet (back-to-back, no bubble).
- ISSUE with `alu_wready`=0 → hold; no accept.

Tag push is gated by count < TAG_DEPTH. A pop in the same cycle does not lift a full condition.

Return path (combinational):
- Tag FIFO non-empty, head h: `rsp_rvalid[h]` = `alu_rvalid`, `rsp_rdata` = `alu_rdata`, `alu_rready` = `rsp_rready[h]`. Pop the tag on `alu_rvalid && alu_rready`.
- Tag FIFO empty: `rsp_rvalid`=0, `alu_rready`=1 (drain). Any `alu_rvalid` sets `err_orphan`, which clears only on reset.

Simultaneous push and pop: count unchanged, both pointers advance.

Packets pass through unmodified; the block never decodes op.

## Timing
- Reset (reset=0) takes effect immediately, without waiting for a clock edge:
  - outputs: `alu_wvalid`=0, `alu_wdata`=0, `req_wready`=0, `rsp_rvalid`=0, `alu_rready`=1, `busy`=0, `err_orphan`=0
  - internal state: FSM=IDLE, `last_grant`=NUM_REQ-1 (requester 0 has first priority), tag pointers and count = 0
- Reset mid-operation discards the slot packet and all tags. The owner must also reset the ALU FIFOs.
- Accept at edge N → `alu_wvalid`=1 with that packet after edge N.
- Sustained throughput: one command per cycle while `alu_wready`=1.
- Return path: zero cycles, combinational from ALU output FIFO to requester.
- Requesters must hold `req_wdata` and `req_wvalid` until accepted.

## Structure
- Package `alu_sched_pkg`:
  - `DATA_W`
  - field localparams `OPA_LSB`=0, `OPB_LSB`=4, `OP_LSB`=8
  - `typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_XOR} alu_op_e`
  - `typedef enum logic {S_IDLE, S_ISSUE} sched_state_e`
- Sub-module `sched_tag_fifo`: TAG_DEPTH × $clog2(NUM_REQ) entries, push/pop/count/full/empty, same async active-low reset.

## Test plan
- Single command: req 0 sends 10'h053 (ADD, a=3, b=5); bench ALU returns 10'h008 → `alu_wdata`=10'h053 one cycle after accept; `rsp_rvalid`=4'b0001, `rsp_rdata`=10'h008; `busy` returns to 0.
- Fairness: all four requesters valid continuously, `alu_wready`=1 → accept order 0,1,2,3,0,1…; in-order results appear on `rsp_rvalid` 0001, 0010, 0100, 1000.
- Full: `alu_rvalid` held 0 → exactly 8 accepts, then `req_wready`=0. One result popped → exactly one further accept, on the next cycle.
- Backpressure: `alu_wready`=0 for 5 cycles while ISSUE → `alu_wdata` stable, no accepts. `alu_wready` returns high → hand-off plus same-cycle accept of the next requester.
- Orphan and ownership: after reset, `alu_rvalid`=1 with 10'h3FF → `alu_rready`=1, `rsp_rvalid`=0, `err_orphan`=1 sticky. Separately, result owner's `rsp_rready`=0 → `alu_rready`=0 and the tag is not popped.
- Async reset: drop reset between edges with 3 outstanding tags → outputs reach reset values before the next edge; the following req 2 command is accepted first only if req 0 and req 1 are idle.
